// File: rtl/jogo_pkg.sv
// Shared game-side definitions: button FSM states, default debounce timing
// and a small elaboration-time helper.
package jogo_pkg;

   typedef enum logic [1:0] {
      SOLTO,
      PRESS_DEB,
      PRESSIONADO,
      SOLTANDO
   } estado_botao_t;

   localparam int DEBOUNCE_TICKS_DEF = 4;
   localparam int LONG_TICKS_DEF     = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser for asynchronous panel inputs; the reset value lets
// active-low signals come out of reset in their inactive state.
module sincronizador #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // NOTE: sequential state uses non-blocking assignments so r_sync takes the
   // old r_meta and the two flops form a real two-stage chain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/leitor_painel.sv
// Player panel reader: synchronises and debounces the slide switches and the
// confirm button, producing confirm, held and long-press indications.
module leitor_painel
   import jogo_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
   parameter int LONG_TICKS     = LONG_TICKS_DEF,
   parameter int N_CH           = 8
) (
   input  logic            clock_in,
   input  logic            reset,
   input  logic            tick,
   input  logic [N_CH-1:0] ch_raw,
   input  logic            btn_n,
   output logic [N_CH-1:0] ch_estavel,
   output logic            ch_mudou,
   output logic            btn_pulso,
   output logic            btn_segurado,
   output logic            btn_longo
);

   localparam int             CW        = $clog2(max_int(DEBOUNCE_TICKS, LONG_TICKS) + 1);
   localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
   localparam logic [CW-1:0]  LONG_MAX  = CW'(LONG_TICKS);
   localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_TICKS - 1);

   if (DEBOUNCE_TICKS < 1 || LONG_TICKS < DEBOUNCE_TICKS) begin : g_param_check
      $error("leitor_painel: need DEBOUNCE_TICKS >= 1 and LONG_TICKS >= DEBOUNCE_TICKS");
   end

   logic [N_CH-1:0] w_ch_sync;
   logic            w_btn_n_sync;
   logic            w_pressed;

   sincronizador #(.WIDTH(N_CH), .RESET_VAL('0)) u_sync_ch (
      .i_clk (clock_in),
      .i_rst (reset),
      .i_d   (ch_raw),
      .o_q   (w_ch_sync)
   );

   sincronizador #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_btn (
      .i_clk (clock_in),
      .i_rst (reset),
      .i_d   (btn_n),
      .o_q   (w_btn_n_sync)
   );

   assign w_pressed = ~w_btn_n_sync;

   // Switch bank: any movement restarts the candidate; it is only accepted
   // after DEBOUNCE_TICKS ticks of stability.
   logic [N_CH-1:0] r_cand;
   logic [N_CH-1:0] r_ch_estavel;
   logic [CW-1:0]   r_cnt_ch;
   logic            r_ch_mudou;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_cand       <= '0;
         r_ch_estavel <= '0;
         r_cnt_ch     <= '0;
         r_ch_mudou   <= 1'b0;
      end else begin
         r_ch_mudou <= 1'b0;
         if (w_ch_sync != r_cand) begin
            r_cand   <= w_ch_sync;
            r_cnt_ch <= '0;
         end else if (r_cand == r_ch_estavel) begin
            r_cnt_ch <= '0;
         end else if (tick) begin
            if (r_cnt_ch == DEB_LAST) begin
               r_ch_estavel <= r_cand;
               r_ch_mudou   <= 1'b1;
               r_cnt_ch     <= '0;
            end else begin
               r_cnt_ch <= r_cnt_ch + 1'b1;
            end
         end
      end
   end

   estado_botao_t r_estado, w_estado_nxt;
   logic [CW-1:0] r_cnt_b, w_cnt_b_nxt;
   logic [CW-1:0] r_cnt_l, w_cnt_l_nxt;
   logic          r_pulso, w_pulso_nxt;
   logic          r_longo, w_longo_nxt;
   logic          r_segurado;

   // NOTE: every signal gets its default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      w_estado_nxt = r_estado;
      w_cnt_b_nxt  = r_cnt_b;
      w_cnt_l_nxt  = r_cnt_l;
      w_pulso_nxt  = 1'b0;
      w_longo_nxt  = 1'b0;
      case (r_estado)
         SOLTO: begin
            if (w_pressed) begin
               w_estado_nxt = PRESS_DEB;
               w_cnt_b_nxt  = '0;
            end
         end
         PRESS_DEB: begin
            if (!w_pressed) begin
               w_estado_nxt = SOLTO;
            end else if (tick) begin
               if (r_cnt_b == DEB_LAST) begin
                  w_estado_nxt = PRESSIONADO;
                  w_pulso_nxt  = 1'b1;
                  w_cnt_l_nxt  = '0;
               end else begin
                  w_cnt_b_nxt = r_cnt_b + 1'b1;
               end
            end
         end
         PRESSIONADO: begin
            if (!w_pressed) begin
               w_estado_nxt = SOLTANDO;
               w_cnt_b_nxt  = '0;
            end else if (tick && r_cnt_l < LONG_MAX) begin
               w_cnt_l_nxt = r_cnt_l + 1'b1;
               w_longo_nxt = (r_cnt_l == LONG_LAST);
            end
         end
         SOLTANDO: begin
            // Release bounce returns to PRESSIONADO with the long count kept.
            if (w_pressed) begin
               w_estado_nxt = PRESSIONADO;
            end else if (tick) begin
               if (r_cnt_b == DEB_LAST) begin
                  w_estado_nxt = SOLTO;
               end else begin
                  w_cnt_b_nxt = r_cnt_b + 1'b1;
               end
            end
         end
         default: w_estado_nxt = SOLTO;
      endcase
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         r_estado   <= SOLTO;
         r_cnt_b    <= '0;
         r_cnt_l    <= '0;
         r_pulso    <= 1'b0;
         r_longo    <= 1'b0;
         r_segurado <= 1'b0;
      end else begin
         r_estado   <= w_estado_nxt;
         r_cnt_b    <= w_cnt_b_nxt;
         r_cnt_l    <= w_cnt_l_nxt;
         r_pulso    <= w_pulso_nxt;
         r_longo    <= w_longo_nxt;
         r_segurado <= (w_estado_nxt == PRESSIONADO) || (w_estado_nxt == SOLTANDO);
      end
   end

   assign ch_estavel   = r_ch_estavel;
   assign ch_mudou     = r_ch_mudou;
   assign btn_pulso    = r_pulso;
   assign btn_segurado = r_segurado;
   assign btn_longo    = r_longo;

endmodule

// File: doc/leitor_painel.md
Name: leitor_painel

Overview:
- Input-side conditioner for the player panel: reads the raw slide switches and the confirm button, and delivers clean, debounced values to the game logic.
- It is the reader counterpart of the LED matrix/display output path.
- Replaces the ad-hoc button level-to-pulse path with one block:
  - 2-flop synchronisers;
  - tick-paced debounce for the 8 switches as a bank;
  - a button FSM producing a confirm pulse, a held level and a long-press pulse (used for game restart).

Parameters:
DEBOUNCE_TICKS, 4, consecutive stable ticks required before a switch or button change is accepted (>=1)
LONG_TICKS, 16, ticks in PRESSIONADO before btn_long fires (>=DEBOUNCE_TICKS)
N_CH, 8, number of slide switches

Ports:
clock_in  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle enable pulse from the frequency divider; all debounce/long counters advance only when tick=1
ch_raw  input  N_CH  raw switch levels (ch7..ch0), asynchronous
btn_n  input  1  raw confirm button, active-low, asynchronous
ch_estavel  output  N_CH  debounced switch bank
ch_mudou  output  1  one-cycle pulse when ch_estavel updates
btn_pulso  output  1  one-cycle confirm pulse per accepted press
btn_segurado  output  1  high while the button is considered pressed (PRESSIONADO or SOLTANDO)
btn_longo  output  1  one-cycle pulse when a press lasts LONG_TICKS ticks

Behaviour:
Reset and outputs
- Reset (async) values:
  - sync flops: ch = 0, btn_n = 1 (released);
  - ch_estavel = 0; all pulses = 0; btn_segurado = 0;
  - FSM = SOLTO; counters = 0.
- Reset mid-operation aborts any pending debounce; no pulse is emitted for that pending change.
- All outputs are registered.

Synchronisation
- 2-flop synchroniser on ch_raw and btn_n. Internal pressed = ~btn_n_sync.
- Sync latency: 2 clocks.

Switch bank (candidate register cand, counter cnt_ch)
- Every clock: if ch_sync != cand, then cand <= ch_sync and cnt_ch <= 0. This holds regardless of tick.
- Else, on tick with cand != ch_estavel:
  - if cnt_ch == DEBOUNCE_TICKS-1: ch_estavel <= cand, ch_mudou <= 1 for one clock, cnt_ch <= 0;
  - otherwise cnt_ch increments.
- cand == ch_estavel leaves cnt_ch held at 0.
- Multiple bits changing together give one ch_mudou.
- A change that reverts before acceptance gives no ch_mudou.
- Switches already up at reset release give one ch_mudou after debounce.

Button FSM (counter cnt_b, long counter cnt_l)
- SOLTO:
  - pressed -> PRESS_DEB, cnt_b = 0.
- PRESS_DEB:
  - ~pressed (any clock) -> SOLTO.
  - tick & pressed & cnt_b == DEBOUNCE_TICKS-1 -> PRESSIONADO, btn_pulso = 1 for exactly the first clock in PRESSIONADO, cnt_l = 0.
  - Otherwise on tick, cnt_b++.
- PRESSIONADO:
  - ~pressed -> SOLTANDO, cnt_b = 0.
  - On tick with cnt_l < LONG_TICKS, cnt_l++.
  - The tick at which cnt_l reaches LONG_TICKS asserts btn_longo for one clock. cnt_l then saturates, so at most one btn_longo per press.
- SOLTANDO:
  - pressed -> PRESSIONADO. No new btn_pulso; cnt_l is kept (release bounce does not restart long-press).
  - tick & ~pressed & cnt_b == DEBOUNCE_TICKS-1 -> SOLTO.
  - Otherwise on tick, cnt_b++.
- btn_segurado = 1 in PRESSIONADO and SOLTANDO.
- btn_pulso and btn_longo may coincide only if LONG_TICKS == 0, which is illegal; the parameter check rejects it.

Latency and counter widths
- A clean press is accepted on the DEBOUNCE_TICKS-th tick after pressed rises (press visible internally 2 clocks after btn_n falls).
- tick asserted every clock is legal; the block then debounces in clocks.
- Counter widths: $clog2(max param + 1). Counters never wrap.

Decomposition:
- Shared package jogo_pkg:
  - button state enum (SOLTO, PRESS_DEB, PRESSIONADO, SOLTANDO);
  - default DEBOUNCE_TICKS/LONG_TICKS constants.
- Sub-module sincronizador (parameter WIDTH, RESET_VAL), instantiated for ch_raw and btn_n.
- Switch debounce and button FSM stay in leitor_painel.

Test Plan:
(All with DEBOUNCE_TICKS=4, LONG_TICKS=16, tick every 4 clocks.)
1. Reset held with ch_raw=0xFF, btn_n=0 -> all outputs 0, FSM SOLTO. Release -> ch_estavel=0xFF with one ch_mudou after 4 ticks; btn_pulso once after 4 ticks.
2. Clean press held 10 ticks, then clean release -> exactly one btn_pulso; btn_segurado high from pulse until 4 ticks after release; no btn_longo.
3. Press bouncing (btn_n low 2 ticks, high 1 clock, low 2 ticks, high) -> no btn_pulso, btn_segurado stays 0.
4. ch_raw 0x00 -> 0x47 with bit0 toggling every 2 clocks for 3 ticks, then stable -> single ch_mudou; ch_estavel=0x47 4 ticks after settling.
5. Press held 20 ticks with a 1-tick release glitch at tick 10 -> one btn_pulso; btn_longo exactly once, at the 16th tick counted in PRESSIONADO.
6. Press, then assert reset after 2 ticks in PRESS_DEB; deassert with button still pressed -> no pulse from the aborted press; a new btn_pulso 4 ticks (+2 sync clocks) after reset release.
